triangle_host: RTL and testbench

//  Host-side driver for the triangle point-enumeration engine. Takes one

---
 rtl/triangle_host.sv | 217 +++++++++++++++++++++
 tb/tb_triangle_host.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/triangle_host.sv
// Host-side driver for the triangle point engine: sends one 3-vertex job, then sums the returned point stream.
// Optional bounding-box check of returned points: define TRI_HOST_BBOX_CHECK_EN.
module triangle_host #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [17:0]      job_vtx,
  output logic             nt,
  output logic [2:0]       xi,
  output logic [2:0]       yi,
  input  logic             busy,
  input  logic             po,
  input  logic [2:0]       xo,
  input  logic [2:0]       yo,
  output logic             res_valid,
  output logic [CNT_W-1:0] res_count,
  output logic [8:0]       res_sum_x,
  output logic [8:0]       res_sum_y,
  output logic             res_tmo,
  output logic             res_err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEND0   = 3'd1;
  localparam logic [2:0] S_SEND1   = 3'd2;
  localparam logic [2:0] S_SEND2   = 3'd3;
  localparam logic [2:0] S_COLLECT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [17:0]      job_q, job_d;
  logic             nt_q, nt_d;
  logic [2:0]       xi_q, xi_d, yi_q, yi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       sx_q, sx_d, sy_q, sy_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic [8:0]       res_sum_x_q, res_sum_x_d, res_sum_y_q, res_sum_y_d;
  logic             res_tmo_q, res_tmo_d;

  logic [9:0] sx_wide, sy_wide;
  logic       tmr_expire;
  logic       collect_end;
  logic       accept;

  assign sx_wide     = {1'b0, sx_q} + {7'd0, xo};
  assign sy_wide     = {1'b0, sy_q} + {7'd0, yo};
  assign tmr_expire  = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
  // Exits never coincide with a point, so the accumulators are already final here.
  assign collect_end = (state_q == S_COLLECT) && !po && (!busy || tmr_expire);
  assign accept      = (state_q == S_IDLE) && job_valid;

  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    nt_d        = 1'b0;
    xi_d        = 3'd0;
    yi_d        = 3'd0;
    cnt_d       = cnt_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    tmr_d       = tmr_q;
    res_valid_d = 1'b0;
    res_count_d = res_count_q;
    res_sum_x_d = res_sum_x_q;
    res_sum_y_d = res_sum_y_q;
    res_tmo_d   = res_tmo_q;
    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          job_d   = job_vtx;
          state_d = S_SEND0;
          nt_d    = 1'b1;
          xi_d    = job_vtx[17:15];
          yi_d    = job_vtx[14:12];
          cnt_d   = '0;
          sx_d    = '0;
          sy_d    = '0;
          tmr_d   = '0;
        end
      end
      S_SEND0: begin
        state_d = S_SEND1;
        xi_d    = job_q[11:9];
        yi_d    = job_q[8:6];
      end
      S_SEND1: begin
        state_d = S_SEND2;
        xi_d    = job_q[5:3];
        yi_d    = job_q[2:0];
      end
      S_SEND2: state_d = S_COLLECT;
      S_COLLECT: begin
        if (po) begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          sx_d  = sx_wide[9] ? 9'd511 : sx_wide[8:0];
          sy_d  = sy_wide[9] ? 9'd511 : sy_wide[8:0];
          tmr_d = '0;
        end else if (busy && !tmr_expire) begin
          tmr_d = tmr_q + TMR_W'(1);
        end
        if (collect_end) begin
          state_d     = S_DONE;
          res_valid_d = 1'b1;
          res_count_d = cnt_q;
          res_sum_x_d = sx_q;
          res_sum_y_d = sy_q;
          res_tmo_d   = busy;
          cnt_d       = '0;
          sx_d        = '0;
          sy_d        = '0;
          tmr_d       = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      job_q       <= '0;
      nt_q        <= 1'b0;
      xi_q        <= '0;
      yi_q        <= '0;
      cnt_q       <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      tmr_q       <= '0;
      res_valid_q <= 1'b0;
      res_count_q <= '0;
      res_sum_x_q <= '0;
      res_sum_y_q <= '0;
      res_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      nt_q        <= nt_d;
      xi_q        <= xi_d;
      yi_q        <= yi_d;
      cnt_q       <= cnt_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      tmr_q       <= tmr_d;
      res_valid_q <= res_valid_d;
      res_count_q <= res_count_d;
      res_sum_x_q <= res_sum_x_d;
      res_sum_y_q <= res_sum_y_d;
      res_tmo_q   <= res_tmo_d;
    end
  end

`ifdef TRI_HOST_BBOX_CHECK_EN
  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    logic [2:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [2:0] max3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    logic [2:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  logic [2:0] x_min, x_max, y_min, y_max;
  logic       out_of_box;
  logic       err_q, err_d, res_err_q, res_err_d;

  assign x_min = min3(job_q[17:15], job_q[11:9], job_q[5:3]);
  assign x_max = max3(job_q[17:15], job_q[11:9], job_q[5:3]);
  assign y_min = min3(job_q[14:12], job_q[8:6], job_q[2:0]);
  assign y_max = max3(job_q[14:12], job_q[8:6], job_q[2:0]);
  assign out_of_box = (xo < x_min) || (xo > x_max) || (yo < y_min) || (yo > y_max);

  always_comb begin
    err_d     = err_q;
    res_err_d = res_err_q;
    if (accept) err_d = 1'b0;
    if ((state_q == S_COLLECT) && po && out_of_box) err_d = 1'b1;
    if (collect_end) res_err_d = err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q     <= 1'b0;
      res_err_q <= 1'b0;
    end else begin
      err_q     <= err_d;
      res_err_q <= res_err_d;
    end
  end

  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  assign job_ready = (state_q == S_IDLE);
  assign nt        = nt_q;
  assign xi        = xi_q;
  assign yi        = yi_q;
  assign res_valid = res_valid_q;
  assign res_count = res_count_q;
  assign res_sum_x = res_sum_x_q;
  assign res_sum_y = res_sum_y_q;
  assign res_tmo   = res_tmo_q;

endmodule

// File: tb/tb_triangle_host.sv
// Directed table-driven bench for triangle_host (TIMEOUT_CYC=8, CNT_W=3 so count saturation is reachable).
module tb_triangle_host;

  localparam int TMO = 8;
  localparam int CW  = 3;
  localparam int NV  = 8;

  logic          clk, reset, job_valid, job_ready, nt, busy, po;
  logic [17:0]   job_vtx;
  logic [2:0]    xi, yi, xo, yo;
  logic          res_valid, res_tmo, res_err;
  logic [CW-1:0] res_count;
  logic [8:0]    res_sum_x, res_sum_y;

  triangle_host #(.TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready), .job_vtx(job_vtx),
    .nt(nt), .xi(xi), .yi(yi), .busy(busy), .po(po), .xo(xo), .yo(yo),
    .res_valid(res_valid), .res_count(res_count), .res_sum_x(res_sum_x), .res_sum_y(res_sum_y),
    .res_tmo(res_tmo), .res_err(res_err)
  );

  typedef struct {
    logic [17:0]     vtx;
    int              npts;
    logic [9:0][2:0] px;
    logic [9:0][2:0] py;
    int              gap;
    bit              tmo_end;
    int              exp_cnt;
    int              exp_sx;
    int              exp_sy;
    bit              exp_tmo;
  } vec_t;

  vec_t vec[NV];
  int   n_vec = 0;
  int   n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int bbox_err(input vec_t v);
    int xmin, xmax, ymin, ymax, e;
    xmin = v.vtx[17:15]; xmax = xmin; ymin = v.vtx[14:12]; ymax = ymin;
    for (int k = 0; k < 2; k++) begin
      int xv, yv;
      xv = (k == 0) ? int'(v.vtx[11:9]) : int'(v.vtx[5:3]);
      yv = (k == 0) ? int'(v.vtx[8:6]) : int'(v.vtx[2:0]);
      if (xv < xmin) xmin = xv;
      if (xv > xmax) xmax = xv;
      if (yv < ymin) ymin = yv;
      if (yv > ymax) ymax = yv;
    end
    e = 0;
    for (int p = 0; p < v.npts; p++)
      if (int'(v.px[p]) < xmin || int'(v.px[p]) > xmax || int'(v.py[p]) < ymin || int'(v.py[p]) > ymax) e = 1;
`ifdef TRI_HOST_BBOX_CHECK_EN
    return e;
`else
    return 0 * e;
`endif
  endfunction

  task automatic set_vec(input int i, input logic [17:0] vtx, input int n, input int gap, input bit tend,
                         input int ec, input int esx, input int esy, input bit etmo);
    vec[i].vtx = vtx; vec[i].npts = n; vec[i].gap = gap; vec[i].tmo_end = tend;
    vec[i].exp_cnt = ec; vec[i].exp_sx = esx; vec[i].exp_sy = esy; vec[i].exp_tmo = etmo;
    vec[i].px = '0; vec[i].py = '0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int  waited, exp_lat, exp_err;
    bit  got;
    exp_err = bbox_err(v);
    chk($sformatf("v%0d ready_idle", id), int'(job_ready), 1);
    job_vtx = v.vtx; job_valid = 1'b1; busy = 1'b1; po = 1'b0;
    @(negedge clk);
    job_vtx = ~v.vtx;  // stays valid outside IDLE; must be ignored
    chk($sformatf("v%0d nt_send0", id), int'(nt), 1);
    chk($sformatf("v%0d xi_send0", id), int'(xi), int'(v.vtx[17:15]));
    chk($sformatf("v%0d yi_send0", id), int'(yi), int'(v.vtx[14:12]));
    chk($sformatf("v%0d ready_busy", id), int'(job_ready), 0);
    @(negedge clk);
    chk($sformatf("v%0d nt_send1", id), int'(nt), 0);
    chk($sformatf("v%0d xy_send1", id), int'({xi, yi}), int'(v.vtx[11:6]));
    @(negedge clk);
    chk($sformatf("v%0d xy_send2", id), int'({nt, xi, yi}), int'({1'b0, v.vtx[5:0]}));
    job_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d xy_collect", id), int'({nt, xi, yi}), 0);
    for (int p = 0; p < v.npts; p++) begin
      repeat (v.gap) begin
        busy = 1'b1; po = 1'b0;
        @(negedge clk);
      end
      po = 1'b1; xo = v.px[p]; yo = v.py[p];
      @(negedge clk);
    end
    po = 1'b0; xo = 3'd0; yo = 3'd0; busy = v.tmo_end;
    exp_lat = v.tmo_end ? TMO : 1;
    waited = 0; got = 1'b0;
    while (!got && waited < 40) begin
      @(negedge clk);
      waited++;
      if (res_valid) got = 1'b1;
    end
    chk($sformatf("v%0d res_valid_latency", id), waited, exp_lat);
    chk($sformatf("v%0d res_count", id), int'(res_count), v.exp_cnt);
    chk($sformatf("v%0d res_sum_x", id), int'(res_sum_x), v.exp_sx);
    chk($sformatf("v%0d res_sum_y", id), int'(res_sum_y), v.exp_sy);
    chk($sformatf("v%0d res_tmo", id), int'(res_tmo), int'(v.exp_tmo));
    chk($sformatf("v%0d res_err", id), int'(res_err), exp_err);
    busy = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d res_valid_pulse", id), int'(res_valid), 0);
    chk($sformatf("v%0d ready_after", id), int'(job_ready), 1);
    chk($sformatf("v%0d res_hold", id), int'(res_count), v.exp_cnt);
    $display("vector %0d: vtx=%h pts=%0d count=%0d sx=%0d sy=%0d tmo=%0d err=%0d",
             id, v.vtx, v.npts, res_count, res_sum_x, res_sum_y, res_tmo, res_err);
  endtask

  initial begin
    reset = 1'b1; job_valid = 1'b0; job_vtx = '0; busy = 1'b0; po = 1'b0; xo = '0; yo = '0;

    // {x0,y0,x1,y1,x2,y2}
    set_vec(0, {3'd1,3'd0,3'd1,3'd2,3'd3,3'd2}, 3, 0, 1'b0, 3, 4, 4, 1'b0);
    vec[0].px[0] = 3'd1; vec[0].py[0] = 3'd1;
    vec[0].px[1] = 3'd2; vec[0].py[1] = 3'd1;
    vec[0].px[2] = 3'd1; vec[0].py[2] = 3'd2;
    set_vec(1, {3'd0,3'd0,3'd7,3'd7,3'd3,3'd5}, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    set_vec(2, {3'd2,3'd3,3'd4,3'd5,3'd6,3'd1}, 0, 0, 1'b1, 0, 0, 0, 1'b1);
    set_vec(3, {3'd7,3'd7,3'd0,3'd0,3'd4,3'd1}, 9, 0, 1'b0, 7, 63, 63, 1'b0);
    for (int p = 0; p < 9; p++) begin
      vec[3].px[p] = 3'd7; vec[3].py[p] = 3'd7;
    end
    set_vec(4, {3'd0,3'd0,3'd7,3'd7,3'd7,3'd0}, 3, TMO - 1, 1'b0, 3, 15, 10, 1'b0);
    vec[4].px[0] = 3'd3; vec[4].py[0] = 3'd4;
    vec[4].px[1] = 3'd5; vec[4].py[1] = 3'd6;
    vec[4].px[2] = 3'd7; vec[4].py[2] = 3'd0;
    set_vec(5, {3'd1,3'd1,3'd6,3'd6,3'd2,3'd5}, 2, 1, 1'b1, 2, 6, 6, 1'b1);
    vec[5].px[0] = 3'd2; vec[5].py[0] = 3'd2;
    vec[5].px[1] = 3'd4; vec[5].py[1] = 3'd4;
    set_vec(6, {3'd1,3'd0,3'd1,3'd2,3'd3,3'd2}, 1, 0, 1'b0, 1, 5, 1, 1'b0);
    vec[6].px[0] = 3'd5; vec[6].py[0] = 3'd1;
    set_vec(7, {3'd1,3'd0,3'd1,3'd2,3'd3,3'd2}, 1, 0, 1'b0, 1, 3, 2, 1'b0);
    vec[7].px[0] = 3'd3; vec[7].py[0] = 3'd2;

    repeat (2) @(negedge clk);
    chk("reset job_ready", int'(job_ready), 1);
    chk("reset nt_xi_yi", int'({nt, xi, yi}), 0);
    chk("reset res_valid", int'(res_valid), 0);
    chk("reset res_fields", int'({res_count, res_sum_x, res_sum_y, res_tmo, res_err}), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset job_ready", int'(job_ready), 1);
    $display("reset: job_ready=%0d nt=%0d res_valid=%0d", job_ready, nt, res_valid);

    for (int i = 0; i < NV; i++) run_vec(i, vec[i]);

    // Reset while the second vertex is on the bus
    job_vtx = vec[0].vtx; job_valid = 1'b1; busy = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    @(negedge clk);
    chk("midrst send1_xi", int'(xi), int'(vec[0].vtx[11:9]));
    reset = 1'b1;
    #1;
    chk("midrst nt", int'(nt), 0);
    chk("midrst xi_yi", int'({xi, yi}), 0);
    chk("midrst job_ready", int'(job_ready), 1);
    chk("midrst res_cleared", int'({res_valid, res_count, res_sum_x, res_sum_y, res_tmo}), 0);
    $display("mid-job reset: nt=%0d job_ready=%0d res_count=%0d", nt, job_ready, res_count);
    @(negedge clk);
    reset = 1'b0; busy = 1'b0;
    @(negedge clk);
    run_vec(8, vec[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
